// File: rtl/reg_file_sequencer_pkg.sv
// Shared types for the register-file sequencer: FSM states, opcode classes, decoded fields.
// Imported by the decoder and the sequencer top.
package reg_file_sequencer_pkg;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_CLR = 4'h3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_NOP = 3'd0,
        C_MOV = 3'd1,
        C_LDI = 3'd2,
        C_CLR = 3'd3,
        C_ALU = 3'd4,
        C_ILL = 3'd5
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic [2:0] fu_op;
        logic [2:0] dr;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [7:0] imm8;
    } dec_t;

    function automatic op_class_t classify(input logic [3:0] op);
        if (op[3])
            return C_ALU;
        case (op)
            OP_NOP:  return C_NOP;
            OP_MOV:  return C_MOV;
            OP_LDI:  return C_LDI;
            OP_CLR:  return C_CLR;
            default: return C_ILL;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_sequencer_if.sv
// Instruction handshake, register-file ports and function-unit ports of the sequencer.
// The master modport is the sequencer side; slave is the surrounding datapath.
interface reg_file_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  rf_A;
    logic [7:0]  rf_B;
    logic [2:0]  rf_AA;
    logic [2:0]  rf_BA;
    logic [2:0]  rf_DA;
    logic [7:0]  rf_Data;
    logic        rf_RW;
    logic [2:0]  fu_op;
    logic [7:0]  fu_a;
    logic [7:0]  fu_b;
    logic        fu_start;
    logic        fu_done;
    logic [7:0]  fu_result;
    logic        done;
    logic        err;

    modport master (
        input  instr, instr_valid, rf_A, rf_B, fu_done, fu_result,
        output instr_ready, rf_AA, rf_BA, rf_DA, rf_Data, rf_RW,
               fu_op, fu_a, fu_b, fu_start, done, err
    );

    modport slave (
        output instr, instr_valid, rf_A, rf_B, fu_done, fu_result,
        input  instr_ready, rf_AA, rf_BA, rf_DA, rf_Data, rf_RW,
               fu_op, fu_a, fu_b, fu_start, done, err
    );
endinterface

// File: rtl/reg_file_sequencer_decode.sv
// Purpose: split a 16-bit instruction into opcode class and register/immediate fields.
// Latency: combinational. Backpressure: none.
module reg_file_sequencer_decode
    import reg_file_sequencer_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        dec
);
    always_comb begin
        dec.cls   = classify(instr[15:12]);
        dec.fu_op = instr[14:12];
        dec.dr    = instr[11:9];
        dec.sa    = instr[8:6];
        dec.sb    = instr[5:3];
        dec.imm8  = instr[7:0];
    end
endmodule

// File: rtl/reg_file_sequencer.sv
// Purpose: multi-cycle sequencer driving register-file reads/writes and an external FU.
// Latency: NOP/illegal retire at T+1, MOV/LDI/CLR write at T+2, ALU writes one cycle after fu_done.
// Backpressure: instr_ready only in IDLE; one instruction in flight.
module reg_file_sequencer (
    input  logic             clk,
    input  logic             reset,
    reg_file_sequencer_if.master bus
);
    import reg_file_sequencer_pkg::*;

    dec_t dec;

    reg_file_sequencer_decode u_decode (
        .instr (bus.instr),
        .dec   (dec)
    );

    state_t     state_q, state_d;
    op_class_t  cls_q, cls_d;
    logic [2:0] dr_q, dr_d;
    logic [7:0] imm_q, imm_d;
    logic       rdy_q, rdy_d;
    logic [2:0] aa_q, aa_d, ba_q, ba_d, da_q, da_d;
    logic [7:0] data_q, data_d;
    logic       rw_q, rw_d;
    logic [2:0] fu_op_q, fu_op_d;
    logic [7:0] fu_a_q, fu_a_d, fu_b_q, fu_b_d;
    logic       fu_start_q, fu_start_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        dr_d       = dr_q;
        imm_d      = imm_q;
        rdy_d      = 1'b0;
        aa_d       = aa_q;
        ba_d       = ba_q;
        da_d       = da_q;
        data_d     = data_q;
        rw_d       = 1'b0;
        fu_op_d    = fu_op_q;
        fu_a_d     = fu_a_q;
        fu_b_d     = fu_b_q;
        fu_start_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && rdy_q) begin
                    // NOP/illegal outcome is known at transfer, so its pulse lands in DECODE.
                    state_d = S_DECODE;
                    cls_d   = dec.cls;
                    dr_d    = dec.dr;
                    imm_d   = dec.imm8;
                    aa_d    = dec.sa;
                    ba_d    = dec.sb;
                    fu_op_d = dec.fu_op;
                    done_d  = (dec.cls == C_NOP);
                    err_d   = (dec.cls == C_ILL);
                end else begin
                    rdy_d = 1'b1;
                end
            end
            S_DECODE: begin
                fu_a_d = bus.rf_A;
                fu_b_d = bus.rf_B;
                case (cls_q)
                    C_MOV, C_LDI, C_CLR: begin
                        state_d = S_WRITE;
                        rw_d    = 1'b1;
                        done_d  = 1'b1;
                        da_d    = dr_q;
                        data_d  = (cls_q == C_MOV) ? bus.rf_A :
                                  (cls_q == C_LDI) ? imm_q : 8'h00;
                    end
                    C_ALU: begin
                        state_d    = S_EXEC;
                        fu_start_d = 1'b1;
                        cnt_d      = '0;
                    end
                    default: begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                cnt_d = cnt_q + 1'b1;
                // fu_done in the start cycle belongs to no request of ours.
                if (!fu_start_q && bus.fu_done) begin
                    state_d = S_WRITE;
                    rw_d    = 1'b1;
                    done_d  = 1'b1;
                    da_d    = dr_q;
                    data_d  = bus.fu_result;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cls_q      <= C_NOP;
            dr_q       <= '0;
            imm_q      <= '0;
            rdy_q      <= 1'b0;
            aa_q       <= '0;
            ba_q       <= '0;
            da_q       <= '0;
            data_q     <= '0;
            rw_q       <= 1'b0;
            fu_op_q    <= '0;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            fu_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            dr_q       <= dr_d;
            imm_q      <= imm_d;
            rdy_q      <= rdy_d;
            aa_q       <= aa_d;
            ba_q       <= ba_d;
            da_q       <= da_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
            fu_op_q    <= fu_op_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            fu_start_q <= fu_start_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.instr_ready = rdy_q;
    assign bus.rf_AA       = aa_q;
    assign bus.rf_BA       = ba_q;
    assign bus.rf_DA       = da_q;
    assign bus.rf_Data     = data_q;
    assign bus.rf_RW       = rw_q;
    assign bus.fu_op       = fu_op_q;
    assign bus.fu_a        = fu_a_q;
    assign bus.fu_b        = fu_b_q;
    assign bus.fu_start    = fu_start_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer with a behavioural 8x8 register file.
// The FU is driven by hand from the stimulus sequence.
module tb_reg_file_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    reg_file_sequencer_if bus ();

    reg_file_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rf_mem [8] = '{default: 8'h00};
    assign bus.rf_A = rf_mem[bus.rf_AA];
    assign bus.rf_B = rf_mem[bus.rf_BA];
    always @(posedge clk)
        if (bus.rf_RW === 1'b1)
            rf_mem[bus.rf_DA] <= bus.rf_Data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for instr_ready, transfers one instruction, returns in cycle T+1.
    task automatic send(input logic [15:0] ins);
        int n;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("send_ready", bus.instr_ready, 1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        tick;
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int err_cyc;
        int err_cnt;
        int rw_seen;

        reset           = 1'b0;
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.fu_done     = 1'b0;
        bus.fu_result   = 8'h00;
        tick;
        tick;
        chk("rst_ready", bus.instr_ready, 0);
        chk("rst_rw", bus.rf_RW, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_fu_start", bus.fu_start, 0);
        chk("rst_data", bus.rf_Data, 0);
        @(negedge clk) reset = 1'b1;
        tick;
        tick;

        // LDI R3 = 0xA5
        send(16'h26A5);
        chk("ldi_t1_rw", bus.rf_RW, 0);
        chk("ldi_t1_done", bus.done, 0);
        tick;
        chk("ldi_t2_rw", bus.rf_RW, 1);
        chk("ldi_t2_da", bus.rf_DA, 3);
        chk("ldi_t2_data", bus.rf_Data, 16'h00A5);
        chk("ldi_t2_done", bus.done, 1);
        chk("ldi_t2_ready", bus.instr_ready, 0);
        tick;
        chk("ldi_t3_rw", bus.rf_RW, 0);
        chk("ldi_t3_ready", bus.instr_ready, 1);
        chk("ldi_t3_r3", rf_mem[3], 16'h00A5);

        // MOV R5 = R3
        send(16'h1AC0);
        chk("mov_t1_aa", bus.rf_AA, 3);
        tick;
        chk("mov_t2_rw", bus.rf_RW, 1);
        chk("mov_t2_da", bus.rf_DA, 5);
        chk("mov_t2_data", bus.rf_Data, 16'h00A5);
        tick;
        chk("mov_t3_r5", rf_mem[5], 16'h00A5);

        // R1 = 0x10, R2 = 0x22, then R4 = FU(1, R1, R2)
        send(16'h2210);
        tick;
        tick;
        send(16'h2422);
        tick;
        tick;
        send(16'h9850);
        chk("alu_t1_aa", bus.rf_AA, 1);
        chk("alu_t1_ba", bus.rf_BA, 2);
        chk("alu_t1_fu_op", bus.fu_op, 1);
        chk("alu_t1_start", bus.fu_start, 0);
        tick;
        chk("alu_t2_start", bus.fu_start, 1);
        chk("alu_t2_fu_a", bus.fu_a, 16'h0010);
        chk("alu_t2_fu_b", bus.fu_b, 16'h0022);
        tick;
        chk("alu_t3_start", bus.fu_start, 0);
        tick;
        chk("alu_t4_rw", bus.rf_RW, 0);
        tick;
        bus.fu_done   = 1'b1;
        bus.fu_result = 8'h32;
        tick;
        bus.fu_done = 1'b0;
        chk("alu_t6_rw", bus.rf_RW, 1);
        chk("alu_t6_da", bus.rf_DA, 4);
        chk("alu_t6_data", bus.rf_Data, 16'h0032);
        chk("alu_t6_done", bus.done, 1);
        tick;
        chk("alu_t7_ready", bus.instr_ready, 1);
        chk("alu_t7_r4", rf_mem[4], 16'h0032);

        // ALU R7: fu_done only in the start cycle (ignored) -> timeout err at T+18
        send(16'hAE50);
        tick;
        bus.fu_done = 1'b1;
        tick;
        bus.fu_done = 1'b0;
        err_cyc = -1;
        err_cnt = 0;
        rw_seen = 0;
        for (int i = 3; i <= 20; i++) begin
            if (bus.err === 1'b1) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = i;
            end
            if (bus.rf_RW !== 1'b0) rw_seen++;
            tick;
        end
        chk("tmo_err_cycle", 16'(err_cyc), 18);
        chk("tmo_err_pulses", 16'(err_cnt), 1);
        chk("tmo_no_write", 16'(rw_seen), 0);
        chk("tmo_ready", bus.instr_ready, 1);
        chk("tmo_r7", rf_mem[7], 0);

        // ALU R7: fu_done on the final count wins over the timeout
        send(16'hAE50);
        tick;
        repeat (15) tick;
        bus.fu_done   = 1'b1;
        bus.fu_result = 8'h5A;
        tick;
        bus.fu_done = 1'b0;
        chk("last_rw", bus.rf_RW, 1);
        chk("last_data", bus.rf_Data, 16'h005A);
        chk("last_err", bus.err, 0);
        tick;
        chk("last_err_after", bus.err, 0);
        chk("last_r7", rf_mem[7], 16'h005A);

        // Illegal opcode and NOP
        send(16'h5000);
        chk("ill_t1_err", bus.err, 1);
        chk("ill_t1_done", bus.done, 0);
        chk("ill_t1_rw", bus.rf_RW, 0);
        tick;
        chk("ill_t2_err", bus.err, 0);
        chk("ill_t2_ready", bus.instr_ready, 1);
        send(16'h0000);
        chk("nop_t1_done", bus.done, 1);
        chk("nop_t1_err", bus.err, 0);
        chk("nop_t1_rw", bus.rf_RW, 0);
        tick;
        chk("nop_t2_done", bus.done, 0);
        chk("nop_t2_rw", bus.rf_RW, 0);

        // Reset during EXEC of ALU R6, then LDI R6 = 0x3C
        send(16'hAC50);
        tick;
        tick;
        #2 reset = 1'b0;
        #1;
        chk("arst_fu_a", bus.fu_a, 0);
        chk("arst_aa", bus.rf_AA, 0);
        chk("arst_ready", bus.instr_ready, 0);
        chk("arst_fu_op", bus.fu_op, 0);
        chk("arst_data", bus.rf_Data, 0);
        @(negedge clk) reset = 1'b1;
        tick;
        tick;
        chk("arst_r6", rf_mem[6], 0);
        send(16'h2C3C);
        tick;
        chk("post_rw", bus.rf_RW, 1);
        chk("post_da", bus.rf_DA, 6);
        chk("post_data", bus.rf_Data, 16'h003C);
        tick;
        chk("post_r6", rf_mem[6], 16'h003C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
